gpio_seg_scan: RTL

- Time-multiplexed scan controller for the 8-digit seven-segment display attached to the GPIO block.
- Takes the eight decoded active-low segment patterns that the GPIO block produces. Drives one shared segment bus plus one active-low digit-select line per digit, cycling through the digits with a programmable slot length and an anti-ghosting blank interval.
- Configured over its own APB slave port, which sits on the same APB fabric as the GPIO block.

---
 rtl/gpio_seg_scan.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gpio_seg_scan.sv
// rtl/gpio_seg_scan.sv - time-multiplexed 8-digit seven-segment scan controller
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   in_p*                    APB slave (CTRL @BASE+0, PERIOD @BASE+4, BLANK @BASE+8)
//   seg_in[63:0]             eight active-low segment patterns, digit i in byte i
//   seg_out[7:0]             shared active-low segment bus
//   dig_sel[7:0]             active-low digit selects, at most one low
//   frame_pulse              high for the final cycle of the last digit's slot
module gpio_seg_scan #(
    parameter logic [31:0] BASE  = 32'h10002010,
    parameter int          CNT_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    input  logic [63:0] seg_in,
    output logic [7:0]  seg_out,
    output logic [7:0]  dig_sel,
    output logic        frame_pulse
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    logic             en;
    logic [2:0]       last;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] blank;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    // Protection and strobes carry no meaning here; only full-word writes exist.
    logic unused_apb;
    assign unused_apb = ^{in_pprot, in_pstrb, in_pwdata};

    // ---------------- APB register window ----------------
    logic sel_ctrl, sel_period, sel_blank, mapped, access;

    assign sel_ctrl   = (in_paddr == BASE);
    assign sel_period = (in_paddr == BASE + 32'd4);
    assign sel_blank  = (in_paddr == BASE + 32'd8);
    assign mapped     = sel_ctrl | sel_period | sel_blank;
    assign access     = in_psel & in_penable;

    assign in_pready  = 1'b1;
    assign in_pslverr = access & ~mapped;

    always_comb begin
        in_prdata = 32'd0;
        if (sel_ctrl)
            in_prdata = {21'd0, last, 7'd0, en};
        else if (sel_period)
            in_prdata = 32'(period);
        else if (sel_blank)
            in_prdata = 32'(blank);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en     <= 1'b0;
            last   <= 3'd7;
            period <= CNT_W'(1000);
            blank  <= CNT_W'(2);
        end else if (access && in_pwrite) begin
            if (sel_ctrl) begin
                en   <= in_pwdata[0];
                last <= in_pwdata[10:8];
            end
            if (sel_period)
                period <= in_pwdata[CNT_W-1:0];
            if (sel_blank)
                blank <= in_pwdata[CNT_W-1:0];
        end
    end

    // ---------------- scan sequencer ----------------
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W:0]   cnt_inc;
    logic             scanning, slot_end, wrap;
    logic [1:0]       first_state;

    assign period_eff  = (period == '0) ? CNT_W'(1) : period;
    assign cnt_inc     = {1'b0, cnt} + 1'b1;
    assign scanning    = (state == S_BLANK) || (state == S_SHOW);
    // >= rather than == so that shrinking PERIOD below cnt still ends the slot.
    assign slot_end    = cnt >= period_eff - CNT_W'(1);
    assign wrap        = idx >= last;
    assign first_state = (blank == '0) ? S_SHOW : S_BLANK;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
        end else if (!en) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
        end else if (!scanning) begin
            state <= first_state;
            cnt   <= '0;
            idx   <= 3'd0;
        end else if (slot_end) begin
            state <= first_state;
            cnt   <= '0;
            idx   <= wrap ? 3'd0 : idx + 3'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= (cnt_inc >= {1'b0, blank}) ? S_SHOW : S_BLANK;
        end
    end

    // Outputs decode straight from registered state; segments pass through live.
    always_comb begin
        seg_out = 8'hFF;
        dig_sel = 8'hFF;
        if (state == S_SHOW) begin
            seg_out = seg_in[{idx, 3'b000} +: 8];
            dig_sel = ~(8'b1 << idx);
        end
    end

    assign frame_pulse = scanning & slot_end & wrap;

endmodule
